// File: rtl/fb_intr_ctrl_if.sv
// Wishbone slave bundle for the interrupt aggregator register aperture.
// Latency: none; this file holds wiring only.
// Backpressure: the slave paces every transfer with a one-cycle WBs_ACK_o pulse.
// Signals: address/cycle/strobe/write-enable/byte-strobe/write-data come from the master;
//          read data and acknowledge come from the slave.
interface fb_intr_ctrl_if #(
    parameter int ADDRWIDTH = 10,
    parameter int DATAWIDTH = 32
);
    logic [ADDRWIDTH-1:0] WBs_ADR_i;
    logic                 WBs_CYC_i;
    logic [3:0]           WBs_BYTE_STB_i;
    logic                 WBs_WE_i;
    logic                 WBs_STB_i;
    logic [DATAWIDTH-1:0] WBs_DAT_i;
    logic [DATAWIDTH-1:0] WBs_DAT_o;
    logic                 WBs_ACK_o;

    modport master (
        output WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
        input  WBs_DAT_o, WBs_ACK_o
    );

    modport slave (
        input  WBs_ADR_i, WBs_CYC_i, WBs_BYTE_STB_i, WBs_WE_i, WBs_STB_i, WBs_DAT_i,
        output WBs_DAT_o, WBs_ACK_o
    );
endinterface

// File: rtl/fb_intr_ctrl.sv
// Interrupt aggregator: syncs sources, latches level/edge events, masks them onto FB_msg_out_o.
// Latency: source change -> STATUS in 3 clocks, -> FB_msg_out_o/Intr_Any_o in 4 clocks; WB ACK 1 clock.
// Backpressure: none on sources; WB requests are acked on alternate cycles while held.
// Ports: WB_CLK/WB_RST (sync, active-high); wb = Wishbone slave (STATUS 0x00, ENABLE 0x04,
//        MODE 0x08, RAW 0x0C, EVT_CNT 0x10); Intr_Src_i raw sources; FB_msg_out_o, Intr_Any_o.
module fb_intr_ctrl #(
    parameter int                   ADDRWIDTH     = 10,
    parameter int                   DATAWIDTH     = 32,
    parameter int                   NUM_SRC       = 4,
    parameter logic [DATAWIDTH-1:0] DEF_REG_VALUE = 32'hFAB_DEF_AC
) (
    input  logic                 WB_CLK,
    input  logic                 WB_RST,
    fb_intr_ctrl_if.slave        wb,
    input  logic [NUM_SRC-1:0]   Intr_Src_i,
    output logic [NUM_SRC-1:0]   FB_msg_out_o,
    output logic                 Intr_Any_o
);

    localparam int AW = ADDRWIDTH - 2;
    localparam logic [AW-1:0] OFS_STATUS = AW'(0);
    localparam logic [AW-1:0] OFS_ENABLE = AW'(1);
    localparam logic [AW-1:0] OFS_MODE   = AW'(2);
    localparam logic [AW-1:0] OFS_RAW    = AW'(3);
    localparam logic [AW-1:0] OFS_EVTCNT = AW'(4);

    logic [AW-1:0]        word_adr;
    logic                 xfer_req;
    logic                 ack_nxt;
    logic                 wr_commit;
    logic                 wr_status;
    logic                 wr_enable;
    logic                 wr_mode;
    logic                 wr_evtcnt;

    logic [NUM_SRC-1:0]   sync_q1;
    logic [NUM_SRC-1:0]   sync_q2;
    logic [NUM_SRC-1:0]   sync_d;
    logic [NUM_SRC-1:0]   rise;
    logic [NUM_SRC-1:0]   evt;

    logic [NUM_SRC-1:0]   status_q;
    logic [NUM_SRC-1:0]   status_clr;
    logic [NUM_SRC-1:0]   enable_q;
    logic [NUM_SRC-1:0]   mode_q;
    logic [7:0]           cnt_q [NUM_SRC];
    logic [NUM_SRC-1:0]   cnt_clr;
    logic [DATAWIDTH-1:0] rdata;

    // Address LSBs and most write-data bits have no meaning in this aperture.
    logic unused_bits;
    assign unused_bits = ^{wb.WBs_ADR_i[1:0], wb.WBs_DAT_i, wb.WBs_BYTE_STB_i};

    // ---------------- Wishbone handshake and write decode ----------------
    assign word_adr  = wb.WBs_ADR_i[ADDRWIDTH-1:2];
    assign xfer_req  = wb.WBs_CYC_i & wb.WBs_STB_i;
    assign ack_nxt   = xfer_req & ~wb.WBs_ACK_o;
    // Commit on the edge that closes the acked cycle, so each transfer writes once.
    assign wr_commit = xfer_req & wb.WBs_WE_i & wb.WBs_ACK_o;
    assign wr_status = wr_commit & (word_adr == OFS_STATUS) & wb.WBs_BYTE_STB_i[0];
    assign wr_enable = wr_commit & (word_adr == OFS_ENABLE) & wb.WBs_BYTE_STB_i[0];
    assign wr_mode   = wr_commit & (word_adr == OFS_MODE)   & wb.WBs_BYTE_STB_i[0];
    assign wr_evtcnt = wr_commit & (word_adr == OFS_EVTCNT);

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            wb.WBs_ACK_o <= 1'b0;
            wb.WBs_DAT_o <= '0;
        end else begin
            wb.WBs_ACK_o <= ack_nxt;
            wb.WBs_DAT_o <= ack_nxt ? rdata : '0;
        end
    end

    // ---------------- Synchroniser and event detection ----------------
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
            sync_d  <= '0;
        end else begin
            sync_q1 <= Intr_Src_i;
            sync_q2 <= sync_q1;
            sync_d  <= sync_q2;
        end
    end

    assign rise = sync_q2 & ~sync_d;
    assign evt  = (mode_q & rise) | (~mode_q & sync_q2);

    // ---------------- Control / status registers ----------------
    assign status_clr = wr_status ? wb.WBs_DAT_i[NUM_SRC-1:0] : '0;

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            status_q <= '0;
            enable_q <= '0;
            mode_q   <= '0;
        end else begin
            // Event is OR'd after the clear: a same-cycle event wins, and a held
            // level source keeps re-setting its bit.
            status_q <= (status_q & ~status_clr) | evt;
            if (wr_enable) enable_q <= wb.WBs_DAT_i[NUM_SRC-1:0];
            if (wr_mode)   mode_q   <= wb.WBs_DAT_i[NUM_SRC-1:0];
        end
    end

    // ---------------- Saturating per-source event counters ----------------
    always_comb begin
        cnt_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cnt_clr[i] = wr_evtcnt & wb.WBs_BYTE_STB_i[i];
        end
    end

    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (cnt_clr[i])
                    cnt_q[i] <= {7'd0, rise[i]};
                else if (rise[i] && (cnt_q[i] != 8'hFF))
                    cnt_q[i] <= cnt_q[i] + 8'd1;
            end
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        rdata = '0;
        case (word_adr)
            OFS_STATUS: rdata[NUM_SRC-1:0] = status_q;
            OFS_ENABLE: rdata[NUM_SRC-1:0] = enable_q;
            OFS_MODE:   rdata[NUM_SRC-1:0] = mode_q;
            OFS_RAW:    rdata[NUM_SRC-1:0] = sync_q2;
            OFS_EVTCNT: begin
                for (int i = 0; i < NUM_SRC; i++) rdata[8*i +: 8] = cnt_q[i];
            end
            default:    rdata = DEF_REG_VALUE;
        endcase
    end

    // ---------------- Interrupt outputs ----------------
    always_ff @(posedge WB_CLK) begin
        if (WB_RST) begin
            FB_msg_out_o <= '0;
            Intr_Any_o   <= 1'b0;
        end else begin
            FB_msg_out_o <= status_q & enable_q;
            Intr_Any_o   <= |(status_q & enable_q);
        end
    end

endmodule

// File: tb/tb_fb_intr_ctrl.sv
// Directed bench for fb_intr_ctrl: register reset values, edge/level capture,
// write-1-to-clear races, counter saturation/clear and reset during a transfer.
module tb_fb_intr_ctrl;

    logic       WB_CLK = 1'b0;
    logic       WB_RST;
    logic [3:0] intr_src;
    logic [3:0] fb_msg;
    logic       intr_any;
    logic [31:0] rd;
    int nvec  = 0;
    int nfail = 0;

    fb_intr_ctrl_if #(.ADDRWIDTH(10), .DATAWIDTH(32)) wb ();

    fb_intr_ctrl #(
        .ADDRWIDTH(10), .DATAWIDTH(32), .NUM_SRC(4), .DEF_REG_VALUE(32'hFABDEFAC)
    ) dut (
        .WB_CLK(WB_CLK),
        .WB_RST(WB_RST),
        .wb(wb),
        .Intr_Src_i(intr_src),
        .FB_msg_out_o(fb_msg),
        .Intr_Any_o(intr_any)
    );

    always #5 WB_CLK = ~WB_CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge WB_CLK);
        #1;
    endtask

    // Returns 1 time unit after the edge that closes the acked cycle (write commit edge).
    task automatic wb_xfer(input logic we, input logic [9:0] adr, input logic [31:0] wdat,
                           input logic [3:0] be, output logic [31:0] rdat);
        int n;
        tick(1);
        wb.WBs_ADR_i      = adr;
        wb.WBs_DAT_i      = wdat;
        wb.WBs_BYTE_STB_i = be;
        wb.WBs_WE_i       = we;
        wb.WBs_CYC_i      = 1'b1;
        wb.WBs_STB_i      = 1'b1;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (wb.WBs_ACK_o !== 1'b1 && n < 16);
        check("ack_seen", 32'(wb.WBs_ACK_o), 32'd1);
        rdat = wb.WBs_DAT_o;
        tick(1);
        wb.WBs_CYC_i = 1'b0;
        wb.WBs_STB_i = 1'b0;
        wb.WBs_WE_i  = 1'b0;
        check("ack_pulse", 32'(wb.WBs_ACK_o), 32'd0);
    endtask

    task automatic wb_write(input logic [9:0] adr, input logic [31:0] wdat, input logic [3:0] be);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, be, dummy);
    endtask

    task automatic read_check(input string tag, input logic [9:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        wb_xfer(1'b0, adr, 32'd0, 4'hF, r);
        check(tag, r, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        WB_RST            = 1'b1;
        intr_src          = 4'h0;
        wb.WBs_ADR_i      = '0;
        wb.WBs_DAT_i      = '0;
        wb.WBs_BYTE_STB_i = 4'h0;
        wb.WBs_WE_i       = 1'b0;
        wb.WBs_CYC_i      = 1'b0;
        wb.WBs_STB_i      = 1'b0;

        // ---- Reset state ----
        tick(3);
        check("rst_fb",   32'(fb_msg),        32'd0);
        check("rst_any",  32'(intr_any),      32'd0);
        check("rst_ack",  32'(wb.WBs_ACK_o),  32'd0);
        check("rst_dato", wb.WBs_DAT_o,       32'd0);
        WB_RST = 1'b0;
        tick(1);

        read_check("rd_status0", 10'h000, 32'h0);
        read_check("rd_enable0", 10'h004, 32'h0);
        read_check("rd_mode0",   10'h008, 32'h0);
        read_check("rd_raw0",    10'h00C, 32'h0);
        read_check("rd_evt0",    10'h010, 32'h0);
        read_check("rd_undef",   10'h020, 32'hFABDEFAC);
        tick(1);
        check("ack_idle", 32'(wb.WBs_ACK_o), 32'd0);

        // ---- Edge capture on source 0 ----
        wb_write(10'h008, 32'hF, 4'h1);
        wb_write(10'h004, 32'h1, 4'h1);
        intr_src[0] = 1'b1;          // edge X
        tick(1);
        intr_src[0] = 1'b0;          // X+1
        tick(2);                     // X+3: STATUS set, output not yet
        check("s0_fb_lat3", 32'(fb_msg), 32'h0);
        tick(1);                     // X+4: output follows
        check("s0_fb_lat4",  32'(fb_msg),   32'h1);
        check("s0_any_lat4", 32'(intr_any), 32'h1);
        read_check("s0_status", 10'h000, 32'h1);
        read_check("s0_evtcnt", 10'h010, 32'h0000_0001);
        read_check("s0_raw",    10'h00C, 32'h0);
        wb_write(10'h000, 32'h1, 4'h1);
        check("s0_fb_at_commit", 32'(fb_msg), 32'h1);
        tick(1);
        check("s0_fb_cleared",  32'(fb_msg),   32'h0);
        check("s0_any_cleared", 32'(intr_any), 32'h0);
        read_check("s0_status_clr", 10'h000, 32'h0);

        // ---- Level mode on source 1 ----
        wb_write(10'h008, 32'hD, 4'h1);
        wb_write(10'h004, 32'h2, 4'h1);
        intr_src[1] = 1'b1;
        tick(4);
        check("s1_fb_level", 32'(fb_msg), 32'h2);
        read_check("s1_raw", 10'h00C, 32'h2);
        wb_write(10'h000, 32'h2, 4'h1);
        read_check("s1_status_held", 10'h000, 32'h2);
        intr_src[1] = 1'b0;
        tick(3);
        wb_write(10'h000, 32'h2, 4'h1);
        read_check("s1_status_clr", 10'h000, 32'h0);
        check("s1_fb_clr", 32'(fb_msg), 32'h0);
        read_check("s1_evtcnt", 10'h010, 32'h0000_0101);

        // ---- Edge on source 2 lands on the clear commit edge ----
        intr_src[2] = 1'b1;          // edge X; commit edge is X+3 = rise capture edge
        wb_write(10'h000, 32'h4, 4'h1);
        read_check("s2_race_status", 10'h000, 32'h4);
        check("s2_fb_masked", 32'(fb_msg), 32'h0);
        wb_write(10'h000, 32'h4, 4'h1);
        read_check("s2_status_clr", 10'h000, 32'h0);
        intr_src[2] = 1'b0;

        // ---- Counter saturation on source 3 ----
        wb_write(10'h004, 32'hF, 4'h1);
        for (int k = 0; k < 300; k++) begin
            intr_src[3] = 1'b1;
            tick(1);
            intr_src[3] = 1'b0;
            tick(1);
        end
        tick(4);
        read_check("s3_evt_sat", 10'h010, 32'hFF01_0101);
        wb_write(10'h010, 32'hFFFF_FFFF, 4'b1000);
        read_check("s3_evt_clr", 10'h010, 32'h0001_0101);
        check("s3_fb",  32'(fb_msg),   32'h8);
        check("s3_any", 32'(intr_any), 32'h1);

        // ---- Reset while a write ACK is pending ----
        tick(1);
        wb.WBs_ADR_i      = 10'h004;
        wb.WBs_DAT_i      = 32'h5;
        wb.WBs_BYTE_STB_i = 4'hF;
        wb.WBs_WE_i       = 1'b1;
        wb.WBs_CYC_i      = 1'b1;
        wb.WBs_STB_i      = 1'b1;
        tick(1);
        check("mid_ack_high", 32'(wb.WBs_ACK_o), 32'd1);
        WB_RST = 1'b1;
        tick(1);
        check("mid_rst_ack", 32'(wb.WBs_ACK_o), 32'd0);
        check("mid_rst_fb",  32'(fb_msg),       32'h0);
        check("mid_rst_any", 32'(intr_any),     32'h0);
        tick(1);
        check("mid_rst_ack2", 32'(wb.WBs_ACK_o), 32'd0);
        wb.WBs_CYC_i = 1'b0;
        wb.WBs_STB_i = 1'b0;
        wb.WBs_WE_i  = 1'b0;
        WB_RST = 1'b0;
        tick(1);
        check("post_rst_ack",  32'(wb.WBs_ACK_o), 32'd0);
        check("post_rst_dato", wb.WBs_DAT_o,      32'd0);
        read_check("post_status", 10'h000, 32'h0);
        read_check("post_enable", 10'h004, 32'h0);
        read_check("post_mode",   10'h008, 32'h0);
        read_check("post_evtcnt", 10'h010, 32'h0);
        check("post_fb", 32'(fb_msg), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
